// File: rtl/lsu.sv
// Load/store unit: takes one memory op at a time from the EXU, issues a
// word-aligned memory request with byte lanes, and returns extended load
// data (or a store ack / alignment error) on the writeback port.
module lsu #(
  parameter int CPU_WIDTH = 32,
  parameter int RF_AW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_we,
  input  logic [2:0]           i_funct3,
  input  logic [CPU_WIDTH-1:0] i_addr,
  input  logic [CPU_WIDTH-1:0] i_wdata,
  input  logic [RF_AW-1:0]     i_rd,
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic                 o_mem_wen,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_wmask,
  input  logic                 i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  output logic                 o_wb_valid,
  input  logic                 i_wb_ready,
  output logic [CPU_WIDTH-1:0] o_wb_data,
  output logic [RF_AW-1:0]     o_wb_rd,
  output logic                 o_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic                 bad_op;
  logic [3:0]           wmask_d;
  logic [CPU_WIDTH-1:0] wdata_d;
  logic [CPU_WIDTH-1:0] rd_shift;
  logic [CPU_WIDTH-1:0] load_data;

  logic [CPU_WIDTH-1:0] mem_addr_q;
  logic                 mem_wen_q;
  logic [CPU_WIDTH-1:0] mem_wdata_q;
  logic [3:0]           mem_wmask_q;
  logic [2:0]           funct3_q;
  logic [1:0]           lane_q;
  logic [CPU_WIDTH-1:0] wb_data_q;
  logic [RF_AW-1:0]     wb_rd_q;
  logic                 err_q;

  assign accept = i_req_valid & o_req_ready;

  // Decode illegal funct3 and misalignment on the incoming op
  always_comb begin
    bad_op = 1'b0;
    case (i_funct3)
      3'b000, 3'b100: bad_op = 1'b0;
      3'b001, 3'b101: bad_op = i_addr[0];
      3'b010:         bad_op = (i_addr[1:0] != 2'b00);
      default:        bad_op = 1'b1;
    endcase
    if (i_we && i_funct3[2]) bad_op = 1'b1;
  end

  // Byte-lane mask and lane-replicated store data
  always_comb begin
    wmask_d = 4'b0000;
    wdata_d = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        wmask_d = 4'b0001 << i_addr[1:0];
        wdata_d = {(CPU_WIDTH/8){i_wdata[7:0]}};
      end
      2'b01: begin
        wmask_d = 4'b0011 << {i_addr[1], 1'b0};
        wdata_d = {(CPU_WIDTH/16){i_wdata[15:0]}};
      end
      default: begin
        wmask_d = 4'b1111;
        wdata_d = i_wdata;
      end
    endcase
    if (!i_we) wmask_d = 4'b0000;
  end

  // Select and extend the addressed lane of the returned word
  always_comb begin
    rd_shift  = i_mem_rdata >> {lane_q, 3'b000};
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{(CPU_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{(CPU_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {{(CPU_WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_data = {{(CPU_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: load_data = i_mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)       state_d = bad_op ? RESP : REQ;
      REQ:  if (i_mem_ready)  state_d = WAIT;
      WAIT: if (i_mem_rvalid) state_d = RESP;
      RESP: if (i_wb_ready)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_mem_valid = (state_q == REQ);
    o_wb_valid  = (state_q == RESP);
    o_err       = (state_q == RESP) && err_q;
  end

  // Request fields captured on accept; load result captured on response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      mem_addr_q  <= {i_addr[CPU_WIDTH-1:2], 2'b00};
      mem_wen_q   <= i_we;
      mem_wdata_q <= wdata_d;
      mem_wmask_q <= wmask_d;
      funct3_q    <= i_funct3;
      lane_q      <= i_addr[1:0];
      wb_data_q   <= '0;
      wb_rd_q     <= (i_we || bad_op) ? '0 : i_rd;
      err_q       <= bad_op;
    end else if (state_q == WAIT && i_mem_rvalid && !mem_wen_q) begin
      wb_data_q   <= load_data;
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wmask = mem_wmask_q;
  assign o_wb_data   = wb_data_q;
  assign o_wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: drives ops at the falling edge, acts as a
// fixed-latency memory, and checks handshakes and data against hand values.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  lsu #(.CPU_WIDTH(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " req_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, " mem_valid"}, 32'(o_mem_valid), 32'd0);
    check({tag, " wb_valid"},  32'(o_wb_valid),  32'd0);
    check({tag, " err"},       32'(o_err),       32'd0);
    check({tag, " mem_wen"},   32'(o_mem_wen),   32'd0);
    check({tag, " wmask"},     32'(o_mem_wmask), 32'd0);
    check({tag, " wb_data"},   o_wb_data,        32'd0);
    check({tag, " wb_rd"},     32'(o_wb_rd),     32'd0);
    check({tag, " mem_addr"},  o_mem_addr,       32'd0);
    check({tag, " mem_wdata"}, o_mem_wdata,      32'd0);
  endtask

  // One complete op. rdly = cycles i_mem_ready stays low in REQ (with a
  // stray rvalid that must be ignored); wbdly = cycles i_wb_ready stays low.
  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                    input logic [31:0] rdata, input int rdly, input int wbdly,
                    input logic eerr, input logic [31:0] emaddr, input logic [31:0] ewdata,
                    input logic [3:0] emask, input logic chk_wb, input logic [31:0] ewb,
                    input logic [4:0] erd);
    @(negedge clk);
    check({tag, " ready before"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_rd = rd;
    @(negedge clk);
    i_req_valid = 1'b0; i_addr = 32'hFFFF_FFFF; i_wdata = 32'h5555_5555; i_rd = 5'h1F;
    check({tag, " ready busy"}, 32'(o_req_ready), 32'd0);
    if (!eerr) begin
      check({tag, " mem_valid"}, 32'(o_mem_valid), 32'd1);
      check({tag, " mem_addr"},  o_mem_addr,  emaddr);
      check({tag, " mem_wen"},   32'(o_mem_wen), 32'(we));
      if (we) begin
        check({tag, " wdata"}, o_mem_wdata, ewdata);
        check({tag, " wmask"}, 32'(o_mem_wmask), 32'(emask));
      end
      for (int i = 0; i < rdly; i++) begin
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_1111;
        @(negedge clk);
        check({tag, " hold mem_valid"}, 32'(o_mem_valid), 32'd1);
        check({tag, " hold mem_addr"},  o_mem_addr, emaddr);
        check({tag, " hold ready"},     32'(o_req_ready), 32'd0);
        check({tag, " hold wen"},       32'(o_mem_wen), 32'(we));
        check({tag, " hold wdata"},     o_mem_wdata, o_mem_wdata === 32'hx ? 32'h0 : (we ? ewdata : o_mem_wdata));
        if (we) check({tag, " hold wmask"}, 32'(o_mem_wmask), 32'(emask));
        check({tag, " no early wb"},    32'(o_wb_valid), 32'd0);
      end
      i_mem_rvalid = 1'b0;
      i_mem_ready = 1'b1;
      @(negedge clk);
      i_mem_ready = 1'b0;
      check({tag, " mem_valid drop"}, 32'(o_mem_valid), 32'd0);
      check({tag, " wait no wb"},     32'(o_wb_valid),  32'd0);
      i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
      @(negedge clk);
      i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    end else begin
      check({tag, " no mem_valid"}, 32'(o_mem_valid), 32'd0);
    end
    for (int i = 0; i <= wbdly; i++) begin
      check({tag, " wb_valid"}, 32'(o_wb_valid), 32'd1);
      check({tag, " err"},      32'(o_err), 32'(eerr));
      check({tag, " wb_rd"},    32'(o_wb_rd), 32'(erd));
      check({tag, " no mem_valid in resp"}, 32'(o_mem_valid), 32'd0);
      if (chk_wb) check({tag, " wb_data"}, o_wb_data, ewb);
      if (i < wbdly) @(negedge clk);
    end
    i_wb_ready = 1'b1;
    @(negedge clk);
    i_wb_ready = 1'b0;
    check({tag, " wb done"},    32'(o_wb_valid), 32'd0);
    check({tag, " idle ready"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; i_req_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = '0;
    i_wdata = '0; i_rd = '0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0; i_wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    //  tag      we  f3      addr          wdata         rd     rdata        rdly wb  err emaddr        ewdata        emask    chkwb ewb           erd
    op("LB",    0, 3'b000, 32'h8000_0003, 32'h0,        5'd5,  32'h80FF_1234, 0, 0, 0, 32'h8000_0000, 32'h0,        4'b0000, 1, 32'hFFFF_FF80, 5'd5);
    op("SH",    1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd7, 32'h0,         0, 0, 0, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 0, 32'h0,         5'd0);
    op("LWmis", 0, 3'b010, 32'h8000_0006, 32'h0,        5'd9,  32'h0,         0, 0, 1, 32'h0,         32'h0,        4'b0000, 1, 32'h0,         5'd0);
    op("SWstl", 1, 3'b010, 32'h0000_0020, 32'h1234_5678, 5'd3, 32'h0,         5, 0, 0, 32'h0000_0020, 32'h1234_5678, 4'b1111, 0, 32'h0,         5'd0);
    op("LWstl", 0, 3'b010, 32'h0000_0010, 32'h0,        5'd4,  32'hDEAD_BEEF, 5, 0, 0, 32'h0000_0010, 32'h0,        4'b0000, 1, 32'hDEAD_BEEF, 5'd4);
    op("LHU",   0, 3'b101, 32'h8000_0002, 32'h0,        5'd11, 32'hF00D_8001, 0, 3, 0, 32'h8000_0000, 32'h0,        4'b0000, 1, 32'h0000_F00D, 5'd11);
    op("SB",    1, 3'b000, 32'h0000_0101, 32'h0000_005A, 5'd2, 32'h0,         0, 0, 0, 32'h0000_0100, 32'h5A5A_5A5A, 4'b0010, 0, 32'h0,         5'd0);
    op("LH",    0, 3'b001, 32'h0000_0200, 32'h0,        5'd12, 32'h0000_8001, 0, 0, 0, 32'h0000_0200, 32'h0,        4'b0000, 1, 32'hFFFF_8001, 5'd12);
    op("LBU",   0, 3'b100, 32'h0000_0302, 32'h0,        5'd13, 32'h00AB_0000, 0, 0, 0, 32'h0000_0300, 32'h0,        4'b0000, 1, 32'h0000_00AB, 5'd13);
    op("ILL3",  0, 3'b011, 32'h0000_0000, 32'h0,        5'd14, 32'h0,         0, 0, 1, 32'h0,         32'h0,        4'b0000, 1, 32'h0,         5'd0);
    op("SBU",   1, 3'b100, 32'h0000_0000, 32'h0,        5'd15, 32'h0,         0, 0, 1, 32'h0,         32'h0,        4'b0000, 1, 32'h0,         5'd0);
    op("LHmis", 0, 3'b001, 32'h0000_0001, 32'h0,        5'd16, 32'h0,         0, 1, 1, 32'h0,         32'h0,        4'b0000, 1, 32'h0,         5'd0);

    // Reset while WAITing for the read response: the late rvalid is dropped
    @(negedge clk);
    i_req_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0040; i_rd = 5'd21;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_mem_ready = 1'b1;
    @(negedge clk);
    i_mem_ready = 1'b0;
    check("rst mid wait no mem_valid", 32'(o_mem_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    check_idle_zero("rst mid");
    @(negedge clk);
    check("rst mid late wb", 32'(o_wb_valid), 32'd0);

    op("postrst", 0, 3'b000, 32'h0000_0050, 32'h0, 5'd22, 32'h0000_00FF, 0, 0, 0, 32'h0000_0050, 32'h0, 4'b0000, 1, 32'hFFFF_FFFF, 5'd22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck design still reaches a verdict
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
